// File: rtl/imager_counter_pkg.sv
// Shared constants and count type for the imager sample/pixel index counter.
package imager_counter_pkg;

  localparam int unsigned IMG_CNT_WIDTH = 8;

  typedef logic [IMG_CNT_WIDTH-1:0] img_cnt_t;

endpackage : imager_counter_pkg

// File: rtl/imager_up_counter.sv
// Enable-gated up counter wrapping at MAX_COUNT, with a one-cycle wrap pulse.
// Defining UP_COUNTER_LOAD_EN adds a synchronous load port pair (load, load_value).
module imager_up_counter
  import imager_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = IMG_CNT_WIDTH,
  parameter int unsigned MAX_COUNT = int'((64'(1) << WIDTH) - 64'(1))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
`ifdef UP_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   WRAP_VAL = {1'b0, MAX_VAL} + {{WIDTH{1'b0}}, 1'b1};

  // A zero terminal count would hold wrap high forever, so refuse to build it.
  if (WIDTH < 1 || WIDTH > 31) begin : g_badWidth
    $error("imager_up_counter: WIDTH must be in 1..31");
  end
  if (MAX_COUNT < 1 || 64'(MAX_COUNT) > ((64'(1) << WIDTH) - 64'(1))) begin : g_badMax
    $error("imager_up_counter: MAX_COUNT must be in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic [WIDTH:0]   w_inc;
  logic             w_atMax;
  logic [WIDTH-1:0] w_nextOut;
  logic             w_nextWrap;

  assign w_inc   = {1'b0, r_out} + {{WIDTH{1'b0}}, 1'b1};
  assign w_atMax = (w_inc == WRAP_VAL);

  always_comb begin
    w_nextOut  = r_out;
    w_nextWrap = 1'b0;
    if (clear) begin
      w_nextOut = '0;
    end
`ifdef UP_COUNTER_LOAD_EN
    else if (load) begin
      w_nextOut = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end
`endif
    else if (enable) begin
      if (w_atMax) begin
        w_nextOut  = '0;
        w_nextWrap = 1'b1;
      end else begin
        w_nextOut = w_inc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_nextOut;
      r_wrap <= w_nextWrap;
    end
  end

  assign out  = r_out;
  assign wrap = r_wrap;

endmodule : imager_up_counter

// File: tb/tb_imager_up_counter.sv
// Directed self-checking bench: one full-range counter and one with MAX_COUNT=9 share stimulus.
// Load checks are included when UP_COUNTER_LOAD_EN is defined.
module tb_imager_up_counter;
  import imager_counter_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     enable;
  logic     clear;
  img_cnt_t out8;
  logic     wrap8;
  img_cnt_t out9;
  logic     wrap9;
`ifdef UP_COUNTER_LOAD_EN
  logic     load;
  img_cnt_t loadValue;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  imager_up_counter #(.WIDTH(8)) dutFull (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
`ifdef UP_COUNTER_LOAD_EN
    .load       (load),
    .load_value (loadValue),
`endif
    .out        (out8),
    .wrap       (wrap8)
  );

  imager_up_counter #(.WIDTH(8), .MAX_COUNT(9)) dutNine (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
`ifdef UP_COUNTER_LOAD_EN
    .load       (load),
    .load_value (loadValue),
`endif
    .out        (out9),
    .wrap       (wrap9)
  );

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it before sampling.
  task automatic applyStimulus(input logic en, input logic clr);
    enable = en;
    clear  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
`ifdef UP_COUNTER_LOAD_EN
    load      = 1'b0;
    loadValue = '0;
`endif
    #2;
    checkOutput("resetOut", out8, 0);
    checkOutput("resetWrap", wrap8, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Asynchronous reset mid-count at 37.
    for (int i = 0; i < 37; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("preResetOut", out8, 37);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncResetOut", out8, 0);
    checkOutput("asyncResetWrap", wrap8, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("heldResetOut", out8, 0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("firstAfterReset", out8, 1);

    // Free run for 260 edges from reset.
    restart();
    for (int i = 1; i <= 260; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("freeOut%0d", i), out8, i % 256);
      checkOutput($sformatf("freeWrap%0d", i), wrap8, (i == 256) ? 1 : 0);
      checkOutput($sformatf("nineOut%0d", i), out9, i % 10);
      checkOutput($sformatf("nineWrap%0d", i), wrap9, (i % 10 == 0) ? 1 : 0);
    end
    checkOutput("freeEnd", out8, 4);

    // Enable gating from 10.
    restart();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("gateStart", out8, 10);
    applyStimulus(1'b1, 1'b0);
    checkOutput("gateOut1", out8, 11);
    checkOutput("gateWrap1", wrap8, 0);
    checkOutput("gateNine1", out9, 1);
    checkOutput("gateNineWrap1", wrap9, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("gateOut2", out8, 11);
    checkOutput("gateWrap2", wrap8, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("gateOut3", out8, 11);
    checkOutput("gateNine3", out9, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("gateOut4", out8, 12);
    checkOutput("gateWrap4", wrap8, 0);
    checkOutput("gateNine4", out9, 2);

    // Clear priority at 200.
    restart();
    for (int i = 0; i < 200; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("clearStart", out8, 200);
    applyStimulus(1'b1, 1'b1);
    checkOutput("clearOut", out8, 0);
    checkOutput("clearWrap", wrap8, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("clearResume", out8, 1);
    checkOutput("clearResumeNine", out9, 1);

    // Clear at the terminal count must not produce a wrap pulse.
    restart();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("nineAtMax", out9, 9);
    applyStimulus(1'b1, 1'b1);
    checkOutput("nineClearOut", out9, 0);
    checkOutput("nineClearWrap", wrap9, 0);

`ifdef UP_COUNTER_LOAD_EN
    restart();
    load      = 1'b1;
    loadValue = 8'd250;
    applyStimulus(1'b1, 1'b0);
    checkOutput("load250", out8, 250);
    checkOutput("load250Wrap", wrap8, 0);
    checkOutput("load250Clamp", out9, 9);
    loadValue = 8'd50;
    applyStimulus(1'b1, 1'b0);
    checkOutput("load50", out8, 50);
    checkOutput("load50Clamp", out9, 9);
    checkOutput("load50ClampWrap", wrap9, 0);
    loadValue = 8'd5;
    applyStimulus(1'b1, 1'b0);
    checkOutput("load5Nine", out9, 5);
    applyStimulus(1'b1, 1'b1);
    checkOutput("clearOverLoad", out8, 0);
    checkOutput("clearOverLoadNine", out9, 0);
    load = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("afterLoad", out8, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_imager_up_counter
